// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the ARM multicycle controller: FSM states, instruction
// fields, condition codes and datapath mux/ALU selects.
package cpu_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH  = 4'd0;
    localparam state_t S_DECODE = 4'd1;
    localparam state_t S_MEMADR = 4'd2;
    localparam state_t S_MEMRD  = 4'd3;
    localparam state_t S_MEMWB  = 4'd4;
    localparam state_t S_MEMWR  = 4'd5;
    localparam state_t S_EXECR  = 4'd6;
    localparam state_t S_EXECI  = 4'd7;
    localparam state_t S_ALUWB  = 4'd8;
    localparam state_t S_BRANCH = 4'd9;

    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Unsupported commands fall back to ADD so the datapath always sees a legal op.
    function automatic logic [1:0] cmd_to_alu(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD:          return ALU_ADD;
            CMD_SUB, CMD_CMP: return ALU_SUB;
            CMD_AND:          return ALU_AND;
            CMD_ORR:          return ALU_ORR;
            default:          return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-field evaluation against the stored {N,Z,C,V} flags.
module cond_check
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       condex
);

    logic n, z, c, v;

    assign {n, z, c, v} = flags;

    always_comb begin
        condex = 1'b0;
        case (cond)
            COND_EQ: condex = z;
            COND_NE: condex = ~z;
            COND_CS: condex = c;
            COND_CC: condex = ~c;
            COND_MI: condex = n;
            COND_PL: condex = ~n;
            COND_VS: condex = v;
            COND_VC: condex = ~v;
            COND_HI: condex = c & ~z;
            COND_LS: condex = ~c | z;
            COND_GE: condex = (n == v);
            COND_LT: condex = (n != v);
            COND_GT: condex = ~z & (n == v);
            COND_LE: condex = z | (n != v);
            COND_AL: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM control unit: main FSM, NZCV flag register and
// conditional gating of every architectural write enable.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] cond,
    input  logic [3:0] rd,
    input  logic [3:0] aluflags,
    output logic       pcwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       adrsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic [1:0] alucontrol
);

    state_t     state, next_state;
    logic [3:0] nzcv;
    logic       condex;
    logic       pcw, irw, rgw, mmw;
    logic       wb_to_pc;

    cond_check u_cond_check (
        .cond   (cond),
        .flags  (nzcv),
        .condex (condex)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // Flags only change when a flag-setting DP instruction actually executes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            nzcv <= 4'b0000;
        else if ((state == S_EXECR || state == S_EXECI) && funct[0] && condex)
            nzcv <= aluflags;
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_MEM:  next_state = S_MEMADR;
                    OP_DP:   next_state = funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:   next_state = S_BRANCH;
                    default: next_state = S_FETCH;
                endcase
            end
            S_MEMADR: next_state = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state = S_MEMWB;
            S_EXECR,
            S_EXECI:  next_state = S_ALUWB;
            default:  next_state = S_FETCH;
        endcase
    end

    assign wb_to_pc = (rd == 4'd15);

    always_comb begin
        pcw        = 1'b0;
        irw        = 1'b0;
        rgw        = 1'b0;
        mmw        = 1'b0;
        adrsrc     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_REG;
        resultsrc  = RES_ALUOUT;
        alucontrol = ALU_ADD;
        case (state)
            S_FETCH: begin
                irw       = 1'b1;
                pcw       = 1'b1;
                alusrca   = 1'b1;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALU;
            end
            S_DECODE: begin
                alusrca = 1'b1;
                alusrcb = SRCB_FOUR;
            end
            S_MEMADR: alusrcb = SRCB_IMM;
            S_MEMRD:  adrsrc  = 1'b1;
            S_MEMWR: begin
                adrsrc = 1'b1;
                mmw    = condex;
            end
            S_MEMWB: begin
                resultsrc = RES_RDATA;
                pcw       = condex & wb_to_pc;
                rgw       = condex & ~wb_to_pc;
            end
            S_EXECR: alucontrol = cmd_to_alu(funct[4:1]);
            S_EXECI: begin
                alusrcb    = SRCB_IMM;
                alucontrol = cmd_to_alu(funct[4:1]);
            end
            S_ALUWB: begin
                pcw = condex & wb_to_pc;
                rgw = condex & ~wb_to_pc & (funct[4:1] != CMD_CMP);
            end
            S_BRANCH: begin
                alusrcb   = SRCB_IMM;
                resultsrc = RES_ALU;
                pcw       = condex;
            end
            default: ;
        endcase
    end

    // Reset holds the FSM in FETCH; masking here keeps FETCH's enables quiet too.
    assign pcwrite  = pcw & ~reset;
    assign irwrite  = irw & ~reset;
    assign regwrite = rgw & ~reset;
    assign memwrite = mmw & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues the expected control
// word for each cycle, a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cond;
    logic [3:0] rd;
    logic [3:0] aluflags;
    logic       pcwrite, irwrite, regwrite, memwrite, adrsrc, alusrca;
    logic [1:0] alusrcb, resultsrc, alucontrol;

    typedef struct {
        logic [11:0] exp;
        string       name;
    } sb_item_t;

    sb_item_t sb[$];
    int       tests  = 0;
    int       failed = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .cond       (cond),
        .rd         (rd),
        .aluflags   (aluflags),
        .pcwrite    (pcwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .memwrite   (memwrite),
        .adrsrc     (adrsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .resultsrc  (resultsrc),
        .alucontrol (alucontrol)
    );

    always #5 clk = ~clk;

    // Word layout: {pcw, irw, regw, memw, adrsrc, alusrca, alusrcb, resultsrc, alucontrol}
    function automatic logic [11:0] mk(input logic pcw, input logic irw, input logic rgw,
                                       input logic mmw, input logic adr, input logic asa,
                                       input logic [1:0] asb, input logic [1:0] rs,
                                       input logic [1:0] ac);
        return {pcw, irw, rgw, mmw, adr, asa, asb, rs, ac};
    endfunction

    task automatic checkOutput(input sb_item_t it);
        logic [11:0] got;
        got = {pcwrite, irwrite, regwrite, memwrite, adrsrc, alusrca,
               alusrcb, resultsrc, alucontrol};
        tests++;
        if (got !== it.exp) begin
            failed++;
            $display("[TB] FAIL %s: got %b expected %b", it.name, got, it.exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) checkOutput(sb.pop_front());
    end

    task automatic expectCycle(input logic [11:0] e, input string name);
        sb.push_back('{exp: e, name: name});
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic [5:0] f, input logic [3:0] c,
                                 input logic [3:0] r, input logic [3:0] fl);
        op       = o;
        funct    = f;
        cond     = c;
        rd       = r;
        aluflags = fl;
    endtask

    task automatic fetchDecode(input string name);
        expectCycle(mk(1, 1, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00), {name, "_fetch"});
        expectCycle(mk(0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00), {name, "_decode"});
    endtask

    task automatic runDp(input string name, input logic [5:0] f, input logic [3:0] c,
                         input logic [3:0] r, input logic [3:0] fl, input logic [1:0] ac,
                         input logic rgw, input logic pcw);
        applyStimulus(2'b00, f, c, r, fl);
        fetchDecode(name);
        expectCycle(mk(0, 0, 0, 0, 0, 0, f[5] ? 2'b01 : 2'b00, 2'b00, ac), {name, "_exec"});
        expectCycle(mk(pcw, 0, rgw, 0, 0, 0, 2'b00, 2'b00, 2'b00), {name, "_aluwb"});
    endtask

    task automatic runLoad(input string name, input logic [3:0] c, input logic [3:0] r,
                           input logic rgw, input logic pcw);
        applyStimulus(2'b01, 6'b011001, c, r, 4'b0000);
        fetchDecode(name);
        expectCycle(mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00), {name, "_memadr"});
        expectCycle(mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00), {name, "_memrd"});
        expectCycle(mk(pcw, 0, rgw, 0, 0, 0, 2'b00, 2'b01, 2'b00), {name, "_memwb"});
    endtask

    task automatic runStore(input string name, input logic [3:0] c, input logic mmw);
        applyStimulus(2'b01, 6'b011000, c, 4'd4, 4'b0000);
        fetchDecode(name);
        expectCycle(mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00), {name, "_memadr"});
        expectCycle(mk(0, 0, 0, mmw, 1, 0, 2'b00, 2'b00, 2'b00), {name, "_memwr"});
    endtask

    task automatic runBranch(input string name, input logic [3:0] c, input logic pcw);
        applyStimulus(2'b10, 6'b100000, c, 4'd0, 4'b0000);
        fetchDecode(name);
        expectCycle(mk(pcw, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00), {name, "_branch"});
    endtask

    // CMP (I=0, cmd=1010, S=1) is the cleanest way to load a chosen NZCV.
    task automatic setFlags(input string name, input logic [3:0] fl);
        runDp(name, 6'b010101, 4'b1110, 4'd0, fl, 2'b01, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [3:0] c;
        logic       pcw;
        string      name;
    } br_vec_t;

    br_vec_t brN[$];
    br_vec_t brC[$];
    br_vec_t brV[$];

    initial begin
        brN = '{'{4'b0100, 1'b1, "bmi_n"}, '{4'b0101, 1'b0, "bpl_n"},
                '{4'b1011, 1'b1, "blt_n"}, '{4'b1010, 1'b0, "bge_n"},
                '{4'b1101, 1'b1, "ble_n"}, '{4'b1100, 1'b0, "bgt_n"},
                '{4'b1110, 1'b1, "bal_n"}, '{4'b1111, 1'b0, "bnv_n"}};
        brC = '{'{4'b1000, 1'b1, "bhi_c"}, '{4'b1001, 1'b0, "bls_c"},
                '{4'b0010, 1'b1, "bcs_c"}, '{4'b0011, 1'b0, "bcc_c"},
                '{4'b0000, 1'b0, "beq_c"}};
        brV = '{'{4'b0110, 1'b1, "bvs_v"}, '{4'b0111, 1'b0, "bvc_v"},
                '{4'b1011, 1'b1, "blt_v"}, '{4'b1100, 1'b0, "bgt_v"}};

        reset = 1'b1;
        applyStimulus(2'b00, 6'b000000, 4'b1110, 4'd0, 4'b0000);
        @(posedge clk);
        #1;
        expectCycle(mk(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00), "reset_hold0");
        expectCycle(mk(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00), "reset_hold1");
        reset = 1'b0;

        runDp("add_imm", 6'b101000, 4'b1110, 4'd1, 4'b0000, 2'b00, 1'b1, 1'b0);
        runDp("subs", 6'b000101, 4'b1110, 4'd2, 4'b0100, 2'b01, 1'b1, 1'b0);
        runBranch("beq_z1", 4'b0000, 1'b1);
        runBranch("bne_z1", 4'b0001, 1'b0);
        runLoad("ldr", 4'b1110, 4'd3, 1'b1, 1'b0);
        setFlags("cmp_clr", 4'b0000);
        runStore("str_eq_z0", 4'b0000, 1'b0);
        runStore("str_al", 4'b1110, 1'b1);
        runBranch("beq_z0", 4'b0000, 1'b0);
        runDp("add_nos", 6'b001000, 4'b1110, 4'd4, 4'b0100, 2'b00, 1'b1, 1'b0);
        runBranch("beq_nos", 4'b0000, 1'b0);
        runDp("subs_skip", 6'b000101, 4'b0000, 4'd5, 4'b0100, 2'b01, 1'b0, 1'b0);
        runBranch("beq_skip", 4'b0000, 1'b0);
        runLoad("ldr_pc", 4'b1110, 4'd15, 1'b0, 1'b1);
        runDp("add_pc", 6'b001000, 4'b1110, 4'd15, 4'b0000, 2'b00, 1'b0, 1'b1);
        runDp("orr", 6'b011000, 4'b1110, 4'd6, 4'b0000, 2'b11, 1'b1, 1'b0);
        runDp("and_imm", 6'b100000, 4'b1110, 4'd7, 4'b0000, 2'b10, 1'b1, 1'b0);
        runDp("other_cmd", 6'b011110, 4'b1110, 4'd8, 4'b0000, 2'b00, 1'b1, 1'b0);

        applyStimulus(2'b11, 6'b000000, 4'b1110, 4'd0, 4'b0000);
        fetchDecode("undef");

        setFlags("cmp_n", 4'b1000);
        foreach (brN[i]) runBranch(brN[i].name, brN[i].c, brN[i].pcw);
        setFlags("cmp_c", 4'b0010);
        foreach (brC[i]) runBranch(brC[i].name, brC[i].c, brC[i].pcw);
        setFlags("cmp_v", 4'b0001);
        foreach (brV[i]) runBranch(brV[i].name, brV[i].c, brV[i].pcw);

        // Abort a load in MEMRD: the MEMWB write must never appear and flags must clear.
        setFlags("cmp_z", 4'b0100);
        applyStimulus(2'b01, 6'b011001, 4'b1110, 4'd3, 4'b0000);
        fetchDecode("ldr_abort");
        expectCycle(mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00), "ldr_abort_memadr");
        sb.push_back('{exp: mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00), name: "ldr_abort_memrd"});
        @(negedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        expectCycle(mk(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00), "abort_no_regwrite");
        expectCycle(mk(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00), "abort_hold");
        reset = 1'b0;
        runBranch("beq_after_rst", 4'b0000, 1'b0);
        runBranch("bne_after_rst", 4'b0001, 1'b1);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            tests++;
            failed++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
